// File: rtl/wb_pkg.sv
// Shared encodings for the write-back stage: result source select and load size.
package wb_pkg;

    typedef enum logic [1:0] {
        SEL_ALU  = 2'b00,
        SEL_MEM  = 2'b01,
        SEL_LINK = 2'b10,
        SEL_RSVD = 2'b11
    } sel_e;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'b00,
        SZ_HALF  = 2'b01,
        SZ_WORD  = 2'b10,
        SZ_WORD2 = 2'b11
    } ld_size_e;

    localparam int LINK_OFFSET = 4;

endpackage

// File: rtl/wb_load_align.sv
// Extracts the addressed byte/half/word from a raw memory word and zero- or sign-extends it.
module wb_load_align
    import wb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] mem,
    input  logic [1:0]        size,
    input  logic              ld_signed,
    input  logic [1:0]        addr_lo,
    output logic [DATA_W-1:0] data
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;
    logic        byte_fill;
    logic        half_fill;

    always_comb begin
        byte_val  = mem[8*int'(addr_lo) +: 8];
        // Halves are always 16-bit aligned, so the low offset bit is ignored.
        half_val  = mem[16*int'(addr_lo[1]) +: 16];
        byte_fill = ld_signed & byte_val[7];
        half_fill = ld_signed & half_val[15];
        case (ld_size_e'(size))
            SZ_BYTE: data = {{(DATA_W-8){byte_fill}}, byte_val};
            SZ_HALF: data = {{(DATA_W-16){half_fill}}, half_val};
            default: data = mem;
        endcase
    end

endmodule

// File: rtl/wb_pipe_stage.sv
// Write-back pipeline stage: formats the result, queues it in a small FIFO and
// presents the head to the register file. Counts every retired (popped) entry.
module wb_pipe_stage
    import wb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [DATA_W-1:0] in_mem,
    input  logic [1:0]        in_sel,
    input  logic [1:0]        in_ld_size,
    input  logic              in_ld_signed,
    input  logic [1:0]        in_addr_lo,
    input  logic              in_wb_en,
    input  logic [ADDR_W-1:0] in_dest,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              wb_en_out,
    output logic [ADDR_W-1:0] dest_out,
    output logic [DATA_W-1:0] wb_result,
    output logic [DATA_W-1:0] pc_out,
    output logic [31:0]       retired
);

    // Both sides use valid/ready: a transfer happens on the rising edge where
    // valid and ready are both high; valid never depends on ready.

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]      wr_ptr;
    logic [PTR_W:0]      rd_ptr;
    logic                full;
    logic                empty;
    logic                push;
    logic                pop;
    logic [DATA_W-1:0]   load_data;
    logic [DATA_W-1:0]   fmt_result;

    logic [DATA_W-1:0]   result_mem [DEPTH];
    logic [DATA_W-1:0]   pc_mem     [DEPTH];
    logic [ADDR_W-1:0]   dest_mem   [DEPTH];
    logic                wb_en_mem  [DEPTH];

    wb_load_align #(
        .DATA_W (DATA_W)
    ) u_load_align (
        .mem       (in_mem),
        .size      (in_ld_size),
        .ld_signed (in_ld_signed),
        .addr_lo   (in_addr_lo),
        .data      (load_data)
    );

    always_comb begin
        case (sel_e'(in_sel))
            SEL_MEM:  fmt_result = load_data;
            SEL_LINK: fmt_result = in_pc + DATA_W'(LINK_OFFSET);
            default:  fmt_result = in_alu;
        endcase
    end

    // Extra pointer bit separates full from empty when the index bits match.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign in_ready = !full;
    assign out_valid = !empty;
    assign push     = in_valid && in_ready && !flush;
    assign pop      = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            retired <= '0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
            end
            if (pop) retired <= retired + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            result_mem[wr_ptr[PTR_W-1:0]] <= fmt_result;
            pc_mem[wr_ptr[PTR_W-1:0]]     <= in_pc;
            dest_mem[wr_ptr[PTR_W-1:0]]   <= in_dest;
            wb_en_mem[wr_ptr[PTR_W-1:0]]  <= in_wb_en;
        end
    end

    assign wb_result = result_mem[rd_ptr[PTR_W-1:0]];
    assign pc_out    = pc_mem[rd_ptr[PTR_W-1:0]];
    assign dest_out  = dest_mem[rd_ptr[PTR_W-1:0]];
    // Register 0 is hardwired, so its writes retire without asserting the write enable.
    assign wb_en_out = out_valid && wb_en_mem[rd_ptr[PTR_W-1:0]] &&
                       (dest_mem[rd_ptr[PTR_W-1:0]] != '0);

endmodule

// File: tb/tb_wb_pipe_stage.sv
// Directed self-checking bench for wb_pipe_stage: inputs driven and outputs sampled on the falling edge.
module tb_wb_pipe_stage;
    import wb_pkg::*;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 2;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_pc;
    logic [DATA_W-1:0] in_alu;
    logic [DATA_W-1:0] in_mem;
    logic [1:0]        in_sel;
    logic [1:0]        in_ld_size;
    logic              in_ld_signed;
    logic [1:0]        in_addr_lo;
    logic              in_wb_en;
    logic [ADDR_W-1:0] in_dest;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic              wb_en_out;
    logic [ADDR_W-1:0] dest_out;
    logic [DATA_W-1:0] wb_result;
    logic [DATA_W-1:0] pc_out;
    logic [31:0]       retired;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_retired;

    wb_pipe_stage #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pc        (in_pc),
        .in_alu       (in_alu),
        .in_mem       (in_mem),
        .in_sel       (in_sel),
        .in_ld_size   (in_ld_size),
        .in_ld_signed (in_ld_signed),
        .in_addr_lo   (in_addr_lo),
        .in_wb_en     (in_wb_en),
        .in_dest      (in_dest),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .wb_en_out    (wb_en_out),
        .dest_out     (dest_out),
        .wb_result    (wb_result),
        .pc_out       (pc_out),
        .retired      (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_idle();
        in_valid     = 1'b0;
        in_pc        = '0;
        in_alu       = '0;
        in_mem       = '0;
        in_sel       = SEL_ALU;
        in_ld_size   = SZ_WORD;
        in_ld_signed = 1'b0;
        in_addr_lo   = 2'd0;
        in_wb_en     = 1'b0;
        in_dest      = '0;
        flush        = 1'b0;
    endtask

    task automatic drive_entry(input logic [1:0] sel, input logic [31:0] pc, input logic [31:0] alu,
                               input logic [4:0] dest, input logic wb_en);
        drive_idle();
        in_valid = 1'b1;
        in_sel   = sel;
        in_pc    = pc;
        in_alu   = alu;
        in_dest  = dest;
        in_wb_en = wb_en;
    endtask

    task automatic drive_load(input logic [31:0] mem, input logic [1:0] size, input logic sgn,
                              input logic [1:0] off, input logic [4:0] dest);
        drive_idle();
        in_valid     = 1'b1;
        in_sel       = SEL_MEM;
        in_mem       = mem;
        in_ld_size   = size;
        in_ld_signed = sgn;
        in_addr_lo   = off;
        in_dest      = dest;
        in_wb_en     = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        out_ready = 1'b0;
        drive_idle();
        repeat (2) @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        checks++; if (wb_en_out !== 1'b0) begin failures++; $display("FAIL reset_wb_en_out: got %0b want 0", wb_en_out); end
        checks++; if (retired !== 32'd0) begin failures++; $display("FAIL reset_retired: got %0d want 0", retired); end
        rst = 1'b1;
        exp_retired = 32'd0;
    endtask

    task automatic test_alu();
        @(negedge clk);
        out_ready = 1'b1;
        drive_entry(SEL_ALU, 32'h0000_0100, 32'h0000_1234, 5'd3, 1'b1);
        @(negedge clk);
        drive_idle();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL alu_valid: got %0b want 1", out_valid); end
        checks++; if (wb_result !== 32'h0000_1234) begin failures++; $display("FAIL alu_result: got %h want 00001234", wb_result); end
        checks++; if (dest_out !== 5'd3) begin failures++; $display("FAIL alu_dest: got %0d want 3", dest_out); end
        checks++; if (wb_en_out !== 1'b1) begin failures++; $display("FAIL alu_wb_en: got %0b want 1", wb_en_out); end
        checks++; if (pc_out !== 32'h0000_0100) begin failures++; $display("FAIL alu_pc: got %h want 00000100", pc_out); end
        exp_retired++;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL alu_drained: got %0b want 0", out_valid); end
        checks++; if (retired !== exp_retired) begin failures++; $display("FAIL alu_retired: got %0d want %0d", retired, exp_retired); end
    endtask

    task automatic test_mem_loads();
        logic [1:0]  sz  [8];
        logic        sgn [8];
        logic [1:0]  off [8];
        logic [31:0] exp [8];
        sz  = '{SZ_BYTE, SZ_BYTE, SZ_BYTE, SZ_HALF, SZ_HALF, SZ_HALF, SZ_WORD2, SZ_BYTE};
        sgn = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        off = '{2'd1, 2'd3, 2'd2, 2'd2, 2'd3, 2'd0, 2'd1, 2'd0};
        exp = '{32'h0000_007F, 32'hFFFF_FF80, 32'h0000_00FF, 32'hFFFF_80FF,
                32'h0000_80FF, 32'h0000_7F01, 32'h80FF_7F01, 32'h0000_0001};
        out_ready = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if (out_valid !== 1'b1 || wb_result !== exp[i-1]) begin
                    failures++;
                    $display("FAIL load_%0d: got valid=%0b result=%h want valid=1 result=%h", i-1, out_valid, wb_result, exp[i-1]);
                end
                exp_retired++;
            end
            if (i < 8) drive_load(32'h80FF_7F01, sz[i], sgn[i], off[i], 5'd4);
            else drive_idle();
        end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL load_drained: got %0b want 0", out_valid); end
        checks++; if (retired !== exp_retired) begin failures++; $display("FAIL load_retired: got %0d want %0d", retired, exp_retired); end
    endtask

    task automatic test_link_r0();
        logic [1:0]  sel  [3];
        logic [31:0] pc   [3];
        logic [31:0] alu  [3];
        logic [4:0]  dest [3];
        logic        wen  [3];
        logic [31:0] exp_res [3];
        logic        exp_wen [3];
        sel  = '{SEL_LINK, SEL_ALU, SEL_RSVD};
        pc   = '{32'hFFFF_FFFC, 32'h0000_0200, 32'h0000_0204};
        alu  = '{32'h1111_1111, 32'h0000_0055, 32'hDEAD_BEEF};
        dest = '{5'd5, 5'd0, 5'd7};
        wen  = '{1'b1, 1'b1, 1'b0};
        exp_res = '{32'h0000_0000, 32'h0000_0055, 32'hDEAD_BEEF};
        exp_wen = '{1'b1, 1'b0, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i <= 3; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if (out_valid !== 1'b1 || wb_result !== exp_res[i-1] || wb_en_out !== exp_wen[i-1] ||
                    pc_out !== pc[i-1] || dest_out !== dest[i-1]) begin
                    failures++;
                    $display("FAIL link_r0_%0d: got valid=%0b result=%h wb_en=%0b pc=%h dest=%0d want valid=1 result=%h wb_en=%0b pc=%h dest=%0d",
                             i-1, out_valid, wb_result, wb_en_out, pc_out, dest_out,
                             exp_res[i-1], exp_wen[i-1], pc[i-1], dest[i-1]);
                end
                exp_retired++;
            end
            if (i < 3) drive_entry(sel[i], pc[i], alu[i], dest[i], wen[i]);
            else drive_idle();
        end
        @(negedge clk);
        checks++; if (retired !== exp_retired) begin failures++; $display("FAIL link_r0_retired: got %0d want %0d", retired, exp_retired); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        @(negedge clk);
        drive_entry(SEL_ALU, 32'h0, 32'h0000_000A, 5'd1, 1'b1);
        @(negedge clk);
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b1) begin failures++; $display("FAIL bp_one: got in_ready=%0b out_valid=%0b want 1 1", in_ready, out_valid); end
        drive_entry(SEL_ALU, 32'h0, 32'h0000_000B, 5'd2, 1'b1);
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_full: got in_ready=%0b want 0", in_ready); end
        drive_entry(SEL_ALU, 32'h0, 32'h0000_000C, 5'd3, 1'b1);
        @(negedge clk);
        checks++; if (in_ready !== 1'b0 || wb_result !== 32'h0000_000A) begin failures++; $display("FAIL bp_hold: got in_ready=%0b head=%h want 0 0000000a", in_ready, wb_result); end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || wb_result !== 32'h0000_000B || in_ready !== 1'b1) begin failures++; $display("FAIL bp_b: got valid=%0b head=%h in_ready=%0b want 1 0000000b 1", out_valid, wb_result, in_ready); end
        @(negedge clk);
        drive_idle();
        checks++; if (out_valid !== 1'b1 || wb_result !== 32'h0000_000C || dest_out !== 5'd3) begin failures++; $display("FAIL bp_c: got valid=%0b head=%h dest=%0d want 1 0000000c 3", out_valid, wb_result, dest_out); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_no_dup: got %0b want 0", out_valid); end
        exp_retired = exp_retired + 32'd3;
        checks++; if (retired !== exp_retired) begin failures++; $display("FAIL bp_retired: got %0d want %0d", retired, exp_retired); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        @(negedge clk);
        drive_entry(SEL_ALU, 32'h0, 32'h0000_000D, 5'd1, 1'b1);
        @(negedge clk);
        drive_entry(SEL_ALU, 32'h0, 32'h0000_000E, 5'd2, 1'b1);
        @(negedge clk);
        drive_entry(SEL_ALU, 32'h0, 32'h0000_000F, 5'd3, 1'b1);
        flush = 1'b1;
        out_ready = 1'b1;
        exp_retired++;
        @(negedge clk);
        drive_idle();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL flush_full: got valid=%0b in_ready=%0b want 0 1", out_valid, in_ready); end
        checks++; if (retired !== exp_retired) begin failures++; $display("FAIL flush_retired: got %0d want %0d", retired, exp_retired); end
        @(negedge clk);
        drive_entry(SEL_ALU, 32'h0, 32'h0000_0010, 5'd4, 1'b1);
        @(negedge clk);
        drive_entry(SEL_ALU, 32'h0, 32'h0000_0011, 5'd5, 1'b1);
        flush = 1'b1;
        @(negedge clk);
        drive_idle();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_drop: got %0b want 0", out_valid); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || retired !== exp_retired) begin failures++; $display("FAIL flush_after: got valid=%0b retired=%0d want 0 %0d", out_valid, retired, exp_retired); end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        @(negedge clk);
        drive_entry(SEL_ALU, 32'h0, 32'h0000_0066, 5'd6, 1'b1);
        @(negedge clk);
        drive_entry(SEL_ALU, 32'h0, 32'h0000_0067, 5'd7, 1'b1);
        @(negedge clk);
        drive_idle();
        #2 rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || wb_en_out !== 1'b0) begin failures++; $display("FAIL arst_valid: got valid=%0b wb_en=%0b want 0 0", out_valid, wb_en_out); end
        checks++; if (retired !== 32'd0 || in_ready !== 1'b1) begin failures++; $display("FAIL arst_state: got retired=%0d in_ready=%0b want 0 1", retired, in_ready); end
        exp_retired = 32'd0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        out_ready = 1'b1;
        drive_entry(SEL_ALU, 32'h0, 32'h0000_0077, 5'd9, 1'b1);
        @(negedge clk);
        drive_idle();
        checks++; if (out_valid !== 1'b1 || wb_result !== 32'h0000_0077 || dest_out !== 5'd9) begin failures++; $display("FAIL arst_first: got valid=%0b head=%h dest=%0d want 1 00000077 9", out_valid, wb_result, dest_out); end
        exp_retired++;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || retired !== exp_retired) begin failures++; $display("FAIL arst_after: got valid=%0b retired=%0d want 0 %0d", out_valid, retired, exp_retired); end
    endtask

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: got timeout want completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_alu();
        test_mem_loads();
        test_link_r0();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
